interrupt_priority_resolver: RTL and testbench

//  Upstream stage of the PIC control unit. Holds the request register (IRR) and the in-service register (ISR).

---
 rtl/pic_pkg.sv | 15 +
 rtl/interrupt_priority_resolver_if.sv | 30 +++
 rtl/rot_priority_encoder.sv | 30 +++
 rtl/interrupt_priority_resolver.sv | 157 +++++++++++++++
 tb/tb_interrupt_priority_resolver.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
// Shared definitions for the PIC priority resolver.
//   INTA_* : encodings of the control unit's INTA_COUNT acknowledge phase
//   rank() : priority rank of a level under a rotating lowest-priority pointer,
//            0 = highest (level lp+1), 7 = lowest (level lp itself)
package pic_pkg;

  localparam logic [1:0] INTA_IDLE  = 2'b00;
  localparam logic [1:0] INTA_FIRST = 2'b01;
  localparam logic [1:0] INTA_DONE  = 2'b10;

  function automatic logic [2:0] rank(input logic [2:0] level, input logic [2:0] lp);
    return level - lp - 3'd1;
  endfunction

endpackage

// File: rtl/interrupt_priority_resolver_if.sv
// Handshake bundle between the PIC control unit (master) and the priority
// resolver (slave).
//   INTA_COUNT   : acknowledge phase, 00 idle, 01 first INTA, 10 done
//   EOI          : one-cycle non-specific end-of-interrupt
//   EOI_SPEC     : one-cycle specific end-of-interrupt for EOI_LEVEL
//   RIRR / RISR  : readback selects (RISR wins)
//   INTERNAL_INT : registered interrupt request towards the control unit
//   IR_NUM       : registered winning level
//   READ_DATA    : registered IRR / ISR readback
interface interrupt_priority_resolver_if;
  logic [1:0] INTA_COUNT;
  logic       EOI;
  logic       EOI_SPEC;
  logic [2:0] EOI_LEVEL;
  logic       RIRR;
  logic       RISR;
  logic       INTERNAL_INT;
  logic [2:0] IR_NUM;
  logic [7:0] READ_DATA;

  modport master (
    output INTA_COUNT, EOI, EOI_SPEC, EOI_LEVEL, RIRR, RISR,
    input  INTERNAL_INT, IR_NUM, READ_DATA
  );

  modport slave (
    input  INTA_COUNT, EOI, EOI_SPEC, EOI_LEVEL, RIRR, RISR,
    output INTERNAL_INT, IR_NUM, READ_DATA
  );
endinterface

// File: rtl/rot_priority_encoder.sv
// Rotating priority encoder, purely combinational.
//   req_i   : request vector, bit i = level i
//   lp_i    : current lowest-priority level; scan starts at lp_i+1 and wraps
//   valid_o : at least one request bit set
//   level_o : highest-priority requesting level (0 when nothing is set)
module rot_priority_encoder (
  input  logic [7:0] req_i,
  input  logic [2:0] lp_i,
  output logic       valid_o,
  output logic [2:0] level_o
);

  logic [2:0] idx;
  logic       found;

  always_comb begin
    found   = 1'b0;
    level_o = '0;
    idx     = '0;
    for (int k = 0; k < 8; k++) begin
      idx = lp_i + 3'd1 + 3'(k);
      if (!found && req_i[idx]) begin
        found   = 1'b1;
        level_o = idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/interrupt_priority_resolver.sv
// Upstream stage of the PIC control unit: request register (IRR), in-service
// register (ISR), masking and rotating-priority resolution with fully nested
// blocking. Follows the control unit's INTA_COUNT handshake, EOI commands and
// readback selects.
//
// Ports
//   CLK, RST_      : clock, asynchronous active-low reset
//   IR             : raw interrupt request lines
//   LEVEL          : 1 = level-triggered, 0 = edge-triggered
//   interrupt_mask : 1 = request masked
//   R              : automatic rotation on EOI / AEOI
//   AEOI           : clear ISR at the end of the second INTA
//   bus            : control-unit handshake (slave side)
//
// Build option
//   PIC_IR_SYNC_EN : when defined, IR passes a SYNC_STAGES-deep flop chain
//                    before detection; otherwise IR must already be
//                    synchronous to CLK.
module interrupt_priority_resolver
  import pic_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] RESET_LP    = 3'd7
) (
  input  logic                          CLK,
  input  logic                          RST_,
  input  logic [7:0]                    IR,
  input  logic                          LEVEL,
  input  logic [7:0]                    interrupt_mask,
  input  logic                          R,
  input  logic                          AEOI,
  interrupt_priority_resolver_if.slave  bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be 2 or 3");
  end

  logic [7:0] ir_s;

`ifdef PIC_IR_SYNC_EN
  logic [7:0] sync_q [SYNC_STAGES];

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= IR;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign ir_s = sync_q[SYNC_STAGES-1];
`else
  assign ir_s = IR;
`endif

  logic [1:0] inta_q;
  logic       freeze_q, freeze_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] lp_q, lp_d;
  logic       int_q, int_d;
  logic [2:0] num_q, num_d;
  logic [7:0] rd_q, rd_d;
  logic [7:0] ir_prev_q;

  logic       win_valid, isr_valid;
  logic [2:0] win_lvl, isr_top;

  rot_priority_encoder u_cand_enc (
    .req_i   (irr_q & ~interrupt_mask),
    .lp_i    (lp_q),
    .valid_o (win_valid),
    .level_o (win_lvl)
  );

  rot_priority_encoder u_isr_enc (
    .req_i   (isr_q),
    .lp_i    (lp_q),
    .valid_o (isr_valid),
    .level_o (isr_top)
  );

  logic       first_inta, second_inta, nest_ok;
  logic [7:0] num_1h, isr_clr;

  // inta_q resets to DONE so a phase left over from before reset cannot look
  // like a fresh 00->01; the second INTA only counts while frozen.
  assign first_inta  = (inta_q == INTA_IDLE) && (bus.INTA_COUNT == INTA_FIRST);
  assign second_inta = freeze_q && (inta_q == INTA_FIRST) && (bus.INTA_COUNT == INTA_DONE);
  assign num_1h      = 8'b1 << num_q;
  assign nest_ok     = !isr_valid || (rank(win_lvl, lp_q) < rank(isr_top, lp_q));

  always_comb begin
    if (LEVEL) irr_d = ir_s;
    else       irr_d = (irr_q | (ir_s & ~ir_prev_q)) & ir_s;
    if (first_inta) irr_d = irr_d & ~num_1h;

    // Clears use the pre-edge ISR; a same-edge set of the same bit wins.
    isr_clr = '0;
    if (bus.EOI && isr_valid) isr_clr = isr_clr | (8'b1 << isr_top);
    if (bus.EOI_SPEC)         isr_clr = isr_clr | (8'b1 << bus.EOI_LEVEL);
    if (second_inta && AEOI)  isr_clr = isr_clr | num_1h;
    isr_d = (isr_q & ~isr_clr) | (first_inta ? num_1h : 8'h00);

    lp_d = lp_q;
    if (bus.EOI && isr_valid && R) lp_d = isr_top;
    if (second_inta && AEOI && R)  lp_d = num_q;

    freeze_d = freeze_q;
    if (first_inta)       freeze_d = 1'b1;
    else if (second_inta) freeze_d = 1'b0;

    // While frozen (and on the edge that thaws it) IR_NUM holds and the
    // request stays low; resolution resumes on the following edge.
    int_d = 1'b0;
    num_d = num_q;
    if (!first_inta && !freeze_q && win_valid && nest_ok) begin
      int_d = 1'b1;
      num_d = win_lvl;
    end

    if (bus.RISR)      rd_d = isr_q;
    else if (bus.RIRR) rd_d = irr_q;
    else               rd_d = 8'h00;
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      inta_q    <= INTA_DONE;
      freeze_q  <= 1'b0;
      irr_q     <= '0;
      isr_q     <= '0;
      lp_q      <= RESET_LP;
      int_q     <= 1'b0;
      num_q     <= '0;
      rd_q      <= '0;
      ir_prev_q <= '0;
    end else begin
      inta_q    <= bus.INTA_COUNT;
      freeze_q  <= freeze_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      lp_q      <= lp_d;
      int_q     <= int_d;
      num_q     <= num_d;
      rd_q      <= rd_d;
      ir_prev_q <= ir_s;
    end
  end

  assign bus.INTERNAL_INT = int_q;
  assign bus.IR_NUM       = num_q;
  assign bus.READ_DATA    = rd_q;

endmodule

// File: tb/tb_interrupt_priority_resolver.sv
module tb_interrupt_priority_resolver;

  logic       CLK = 1'b0;
  logic       RST_ = 1'b1;
  logic [7:0] IR = 8'h00;
  logic       LEVEL = 1'b0;
  logic [7:0] interrupt_mask = 8'h00;
  logic       R = 1'b0;
  logic       AEOI = 1'b0;

  interrupt_priority_resolver_if bus();

  interrupt_priority_resolver dut (
    .CLK            (CLK),
    .RST_           (RST_),
    .IR             (IR),
    .LEVEL          (LEVEL),
    .interrupt_mask (interrupt_mask),
    .R              (R),
    .AEOI           (AEOI),
    .bus            (bus)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_ctl(input logic [1:0] inta, input logic eoi, input logic eoi_spec,
                         input logic [2:0] eoi_lvl, input logic rirr, input logic risr);
    bus.INTA_COUNT = inta;
    bus.EOI        = eoi;
    bus.EOI_SPEC   = eoi_spec;
    bus.EOI_LEVEL  = eoi_lvl;
    bus.RIRR       = rirr;
    bus.RISR       = risr;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_ = 1'b0;
    IR = 8'h00; LEVEL = 1'b0; interrupt_mask = 8'h00; R = 1'b0; AEOI = 1'b0;
    set_ctl(2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge CLK);
    RST_ = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_irr, m_isr, m_prev, m_rd;
  int         m_lp, m_num;
  bit         m_int, m_frz;
  logic [1:0] m_inta_prev;

  // first requesting level scanning upward from lp+1, -1 if none
  function automatic int scan_first(input logic [7:0] v, input int lp);
    for (int k = 0; k < 8; k++)
      if (v[(lp + 1 + k) % 8]) return (lp + 1 + k) % 8;
    return -1;
  endfunction

  // 0 = most urgent
  function automatic int urgency(input int lvl, input int lp);
    return (lvl - lp + 7) % 8;
  endfunction

  task automatic model_step();
    int w, t, nlp;
    bit first, second;
    logic [7:0] nirr, nisr, nrd;
    w = scan_first(m_irr & ~interrupt_mask, m_lp);
    t = scan_first(m_isr, m_lp);
    first  = (m_inta_prev == 2'b00) && (bus.INTA_COUNT == 2'b01);
    second = m_frz && (m_inta_prev == 2'b01) && (bus.INTA_COUNT == 2'b10);
    for (int i = 0; i < 8; i++) begin
      if (LEVEL) nirr[i] = IR[i];
      else       nirr[i] = IR[i] && (m_irr[i] || !m_prev[i]);
    end
    if (first) nirr[m_num] = 1'b0;
    nisr = m_isr;
    if (bus.EOI && t >= 0) nisr[t] = 1'b0;
    if (bus.EOI_SPEC) nisr[bus.EOI_LEVEL] = 1'b0;
    if (second && AEOI) nisr[m_num] = 1'b0;
    if (first) nisr[m_num] = 1'b1;
    nlp = m_lp;
    if (bus.EOI && R && t >= 0) nlp = t;
    if (second && AEOI && R) nlp = m_num;
    nrd = bus.RISR ? m_isr : (bus.RIRR ? m_irr : 8'h00);
    if (first || m_frz) m_int = 1'b0;
    else if (w >= 0 && (t < 0 || urgency(w, m_lp) < urgency(t, m_lp))) begin
      m_int = 1'b1;
      m_num = w;
    end else m_int = 1'b0;
    if (first) m_frz = 1'b1;
    else if (second) m_frz = 1'b0;
    m_irr = nirr;
    m_isr = nisr;
    m_lp  = nlp;
    m_rd  = nrd;
    m_prev = IR;
    m_inta_prev = bus.INTA_COUNT;
  endtask

  always @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      m_irr = 8'h00; m_isr = 8'h00; m_prev = 8'h00; m_rd = 8'h00;
      m_lp = 7; m_num = 0; m_int = 1'b0; m_frz = 1'b0; m_inta_prev = 2'b10;
    end else begin
      model_step();
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] ir;
    logic [7:0] mask;
    logic [1:0] inta;
    logic       eoi;
    logic       rirr;
    logic       risr;
    logic       exp_int;
    logic [2:0] exp_num;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [1:0] nxt;
    int r;

    tbl[0]  = '{8'h04, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
    tbl[1]  = '{8'h04, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 8'h04};
    tbl[2]  = '{8'h04, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00};
    tbl[3]  = '{8'h04, 8'h00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'h04};
    tbl[4]  = '{8'h04, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00};
    tbl[5]  = '{8'h04, 8'h00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'h04};
    tbl[6]  = '{8'h04, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00};
    tbl[7]  = '{8'h22, 8'h02, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00};
    tbl[8]  = '{8'h22, 8'h02, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00};
    tbl[9]  = '{8'h22, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00};
    tbl[10] = '{8'h22, 8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00};
    tbl[11] = '{8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'h00};
    tbl[12] = '{8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00};

    set_ctl(2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // reset state
    #1 RST_ = 1'b0;
    #1;
    check("reset int", 8'(bus.INTERNAL_INT), 8'h00);
    check("reset num", 8'(bus.IR_NUM), 8'h00);
    check("reset rd",  bus.READ_DATA, 8'h00);
    @(negedge CLK);
    RST_ = 1'b1;

    // edge capture / ack / EOI / mask scenarios
    for (int i = 0; i < 13; i++) begin
      IR = tbl[i].ir;
      interrupt_mask = tbl[i].mask;
      set_ctl(tbl[i].inta, tbl[i].eoi, 1'b0, 3'd0, tbl[i].rirr, tbl[i].risr);
      tick();
      check($sformatf("vec%0d int", i), 8'(bus.INTERNAL_INT), 8'(tbl[i].exp_int));
      check($sformatf("vec%0d num", i), 8'(bus.IR_NUM), 8'(tbl[i].exp_num));
      check($sformatf("vec%0d rd", i),  bus.READ_DATA, tbl[i].exp_rd);
    end

    // fully nested blocking with IR3 in service
    do_reset();
    IR = 8'h08;
    tick(); tick();
    check("nest ack num", 8'(bus.IR_NUM), 8'h03);
    set_ctl(2'b01, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); tick();
    set_ctl(2'b10, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); tick();
    set_ctl(2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); tick();
    IR = 8'h28;
    tick(); tick();
    check("nest lower blocked", 8'(bus.INTERNAL_INT), 8'h00);
    set_ctl(2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1); tick();
    check("nest isr", bus.READ_DATA, 8'h08);
    IR = 8'h2A;
    tick(); tick();
    check("nest higher int", 8'(bus.INTERNAL_INT), 8'h01);
    check("nest higher num", 8'(bus.IR_NUM), 8'h01);

    // AEOI with rotation, level mode
    do_reset();
    LEVEL = 1'b1; R = 1'b1; AEOI = 1'b1; IR = 8'h03;
    tick(); tick();
    check("rot first num", 8'(bus.IR_NUM), 8'h00);
    set_ctl(2'b01, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1); tick();
    check("rot ack drops int", 8'(bus.INTERNAL_INT), 8'h00);
    set_ctl(2'b10, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1); tick();
    check("rot isr set", bus.READ_DATA, 8'h01);
    set_ctl(2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1); tick();
    check("rot isr aeoi", bus.READ_DATA, 8'h00);
    check("rot next int", 8'(bus.INTERNAL_INT), 8'h01);
    check("rot next num", 8'(bus.IR_NUM), 8'h01);

    // reset in the middle of a handshake
    do_reset();
    IR = 8'h04;
    tick(); tick();
    set_ctl(2'b01, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1); tick(); tick();
    check("midrst pre rd", bus.READ_DATA, 8'h04);
    #2 RST_ = 1'b0;
    IR = 8'h00;
    #1;
    check("midrst int", 8'(bus.INTERNAL_INT), 8'h00);
    check("midrst num", 8'(bus.IR_NUM), 8'h00);
    check("midrst rd",  bus.READ_DATA, 8'h00);
    @(negedge CLK);
    RST_ = 1'b1;
    tick();
    set_ctl(2'b10, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1); tick();
    set_ctl(2'b00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1); tick();
    check("midrst isr", bus.READ_DATA, 8'h00);
    check("midrst no int", 8'(bus.INTERNAL_INT), 8'h00);
    IR = 8'h81;
    tick(); tick();
    check("midrst lp num", 8'(bus.IR_NUM), 8'h00);

    // randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) IR[b] = ~IR[b];
      if ($urandom_range(0, 15) == 0) interrupt_mask = 8'($urandom & $urandom);
      if ($urandom_range(0, 63) == 0) LEVEL = ~LEVEL;
      if ($urandom_range(0, 63) == 0) R = ~R;
      if ($urandom_range(0, 63) == 0) AEOI = ~AEOI;
      case (bus.INTA_COUNT)
        2'b00: nxt = ($urandom_range(0, 3) == 0 || (bus.INTERNAL_INT && $urandom_range(0, 1) == 0)) ? 2'b01 : 2'b00;
        2'b01: begin
          r = $urandom_range(0, 7);
          nxt = (r < 4) ? 2'b10 : ((r == 4) ? 2'b00 : 2'b01);
        end
        default: nxt = 2'b00;
      endcase
      if ($urandom_range(0, 63) == 0) nxt = 2'b11;
      set_ctl(nxt, ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      check("rand int", 8'(bus.INTERNAL_INT), 8'(m_int));
      check("rand num", 8'(bus.IR_NUM), 8'(m_num));
      check("rand rd",  bus.READ_DATA, m_rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
